// File: rtl/window_pkg.sv
// Shared constants for the 3x3 window generator: pixel width, window size, coordinate widths.
// win_off() gives the bit offset of window element (r,c), r=0 oldest row, c=0 leftmost column.
package window_pkg;
  localparam int PIX_W      = 8;
  localparam int WIN_N      = 3;
  localparam int DEF_WIDTH  = 400;
  localparam int DEF_HEIGHT = 300;
  localparam int DEF_X_W    = $clog2(DEF_WIDTH);
  localparam int DEF_Y_W    = $clog2(DEF_HEIGHT);

  function automatic int win_off(input int r, input int c);
    return PIX_W * (WIN_N * r + c);
  endfunction
endpackage

// File: rtl/window_generator_if.sv
// Pixel stream in, window strobe out; slave = window_generator, master = pixel source / window sink.
// No backpressure signals: the sink must take every windowvalid strobe.
interface window_generator_if #(
  parameter int WIDTH  = window_pkg::DEF_WIDTH,
  parameter int HEIGHT = window_pkg::DEF_HEIGHT
);
  localparam int X_W = $clog2(WIDTH);
  localparam int Y_W = $clog2(HEIGHT);

  logic                                                      valid;
  logic [window_pkg::PIX_W-1:0]                              data;
  logic                                                      blankingregion;
  logic [window_pkg::WIN_N*window_pkg::WIN_N*window_pkg::PIX_W-1:0] window;
  logic                                                      windowvalid;
  logic [X_W-1:0]                                            centerx;
  logic [Y_W-1:0]                                            centery;

  modport master (
    output valid, data, blankingregion,
    input  window, windowvalid, centerx, centery
  );

  modport slave (
    input  valid, data, blankingregion,
    output window, windowvalid, centerx, centery
  );
endinterface

// File: rtl/window_generator_line_buffer.sv
// Single-port synchronous RAM, DEPTH x PIX_W; read-before-write, 1-cycle read latency.
// en performs a read of the old contents and a write of wdata at the same address.
module line_buffer
  import window_pkg::*;
#(
  parameter int DEPTH = 400,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             en,
  input  logic [AW-1:0]    addr,
  input  logic [PIX_W-1:0] wdata,
  output logic [PIX_W-1:0] rdata
);
  logic [PIX_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (en) begin
      rdata     <= mem[addr];
      mem[addr] <= wdata;
    end
  end
endmodule

// File: rtl/window_generator.sv
// 3x3 window generator: two line buffers feed a column shift register; 2-cycle latency, no backpressure.
// Defining WINDOW_FRAME_CHECK_EN adds a sticky framefault output for short frames and overrun.
module window_generator
  import window_pkg::*;
#(
  parameter int WIDTH  = 400,
  parameter int HEIGHT = 300
) (
  input logic               clock,
  input logic               reset,
  window_generator_if.slave bus
`ifdef WINDOW_FRAME_CHECK_EN
  ,
  output logic              framefault
`endif
);
  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam int WW = WIN_N * WIN_N * PIX_W;

  logic [XW-1:0]    x, x1, cx1, cx2;
  logic [YW-1:0]    y, cy1, cy2;
  logic             full;
  logic             accept, take, emit0;
  logic             v1, e1, v2, e2;
  logic [PIX_W-1:0] d1, d2, a2, rd_a, rd_b;
  logic [PIX_W-1:0] col [WIN_N];
  logic [PIX_W-1:0] sh0 [WIN_N];
  logic [PIX_W-1:0] sh1 [WIN_N];
  logic [WW-1:0]    win_nxt;

  assign accept = bus.valid & ~bus.blankingregion;
  assign take   = accept & ~full;
  assign emit0  = take && (x >= XW'(2)) && (y >= YW'(2));

  // full marks a completed frame; later pixels are dropped until blanking.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      x    <= '0;
      y    <= '0;
      full <= 1'b0;
    end else if (bus.blankingregion) begin
      x    <= '0;
      y    <= '0;
      full <= 1'b0;
    end else if (take) begin
      if (x == XW'(WIDTH - 1)) begin
        x <= '0;
        if (y == YW'(HEIGHT - 1)) full <= 1'b1;
        else                      y    <= y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

  // B is written one cycle after A because it stores the word A just read out.
  line_buffer #(.DEPTH(WIDTH)) u_buf_a (
    .clock(clock), .en(take), .addr(x), .wdata(bus.data), .rdata(rd_a)
  );
  line_buffer #(.DEPTH(WIDTH)) u_buf_b (
    .clock(clock), .en(v1), .addr(x1), .wdata(rd_a), .rdata(rd_b)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      v1 <= 1'b0; e1 <= 1'b0; d1 <= '0; x1 <= '0; cx1 <= '0; cy1 <= '0;
      v2 <= 1'b0; e2 <= 1'b0; d2 <= '0; a2 <= '0; cx2 <= '0; cy2 <= '0;
    end else begin
      v1 <= take;
      e1 <= emit0;
      if (take) begin
        d1  <= bus.data;
        x1  <= x;
        cx1 <= x - 1'b1;
        cy1 <= y - 1'b1;
      end
      v2 <= v1;
      e2 <= e1;
      if (v1) begin
        d2  <= d1;
        a2  <= rd_a;
        cx2 <= cx1;
        cy2 <= cy1;
      end
    end
  end

  always_comb begin
    col[0]  = rd_b;
    col[1]  = a2;
    col[2]  = d2;
    win_nxt = '0;
    for (int r = 0; r < WIN_N; r++) begin
      win_nxt[win_off(r, 0) +: PIX_W] = sh0[r];
      win_nxt[win_off(r, 1) +: PIX_W] = sh1[r];
      win_nxt[win_off(r, 2) +: PIX_W] = col[r];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < WIN_N; r++) begin
        sh0[r] <= '0;
        sh1[r] <= '0;
      end
      bus.window      <= '0;
      bus.windowvalid <= 1'b0;
      bus.centerx     <= '0;
      bus.centery     <= '0;
    end else begin
      bus.windowvalid <= e2;
      if (v2) begin
        for (int r = 0; r < WIN_N; r++) begin
          sh0[r] <= sh1[r];
          sh1[r] <= col[r];
        end
      end
      if (e2) begin
        bus.window  <= win_nxt;
        bus.centerx <= cx2;
        bus.centery <= cy2;
      end
    end
  end

`ifdef WINDOW_FRAME_CHECK_EN
  logic blank_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      blank_q    <= 1'b0;
      framefault <= 1'b0;
    end else begin
      blank_q <= bus.blankingregion;
      // x/y still hold the pre-blanking position on the rising cycle.
      if ((bus.blankingregion && !blank_q && ((x != '0) || (y != '0)) && !full) ||
          (accept && full))
        framefault <= 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_window_generator.sv
// Directed bench for window_generator at 8x6: ramp frames, valid gaps, blanking, short frame, reset, overrun.
module tb_window_generator;
  localparam int W = 8;
  localparam int H = 6;

  logic clock = 1'b0;
  logic reset;
`ifdef WINDOW_FRAME_CHECK_EN
  logic framefault;
`endif

  window_generator_if #(.WIDTH(W), .HEIGHT(H)) bus ();

  window_generator #(.WIDTH(W), .HEIGHT(H)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
`ifdef WINDOW_FRAME_CHECK_EN
    ,
    .framefault(framefault)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    int          due;
    logic [71:0] win;
    int          cx;
    int          cy;
  } exp_t;

  exp_t        q[$];
  logic [7:0]  img [H][W];
  int          tx, ty, cyc, nassert, nfail, nstrobe;
  bit          tfull, got_first;
  logic [71:0] first_win;
  int          first_cx, first_cy;

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] expv);
    nassert++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
    end
  endtask

  task automatic check_out();
    if (bus.windowvalid === 1'b1) begin
      nstrobe++;
      if (!got_first) begin
        got_first = 1'b1;
        first_win = bus.window;
        first_cx  = int'(bus.centerx);
        first_cy  = int'(bus.centery);
      end
    end
    if (q.size() > 0 && q[0].due == cyc) begin
      chk("strobe", {71'd0, bus.windowvalid}, 72'd1);
      chk("window", bus.window, q[0].win);
      chk("centerx", 72'(bus.centerx), 72'(q[0].cx));
      chk("centery", 72'(bus.centery), 72'(q[0].cy));
      void'(q.pop_front());
    end else begin
      chk("no_strobe", {71'd0, bus.windowvalid}, 72'd0);
    end
  endtask

  // Drive one cycle; the bench's own image model predicts the strobe 2 cycles after the accepting edge.
  task automatic tick(input logic v, input logic b, input logic [7:0] d);
    exp_t e;
    bus.valid          = v;
    bus.blankingregion = b;
    bus.data           = d;
    if (b) begin
      tx = 0; ty = 0; tfull = 1'b0;
    end else if (v && !tfull) begin
      img[ty][tx] = d;
      if (tx >= 2 && ty >= 2) begin
        e.due = cyc + 3;
        e.cx  = tx - 1;
        e.cy  = ty - 1;
        e.win = '0;
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++)
            e.win[8*(3*r+c) +: 8] = img[ty-2+r][tx-2+c];
        q.push_back(e);
      end
      if (tx == W - 1) begin
        tx = 0;
        if (ty == H - 1) tfull = 1'b1;
        else             ty++;
      end else begin
        tx++;
      end
    end
    @(posedge clock);
    #1;
    cyc++;
    check_out();
  endtask

  task automatic frame(input int rows, input bit gap, input int fofs);
    for (int yy = 0; yy < rows; yy++)
      for (int xx = 0; xx < W; xx++) begin
        if (gap) repeat ($urandom_range(0, 1)) tick(1'b0, 1'b0, 8'($urandom));
        tick(1'b1, 1'b0, 8'(xx + 16 * yy + fofs));
      end
  endtask

  task automatic blank(input int n, input logic v);
    repeat (n) tick(v, 1'b1, 8'($urandom));
  endtask

  initial begin
    nassert = 0; nfail = 0; nstrobe = 0; cyc = 0;
    tx = 0; ty = 0; tfull = 1'b0; got_first = 1'b0;
    first_win = '0; first_cx = 0; first_cy = 0;
    reset = 1'b0;
    bus.valid = 1'b0; bus.blankingregion = 1'b1; bus.data = '0;
    #3;
    chk("reset_window", bus.window, 72'd0);
    chk("reset_windowvalid", {71'd0, bus.windowvalid}, 72'd0);
    chk("reset_centerx", 72'(bus.centerx), 72'd0);
    chk("reset_centery", 72'(bus.centery), 72'd0);
`ifdef WINDOW_FRAME_CHECK_EN
    chk("reset_framefault", {71'd0, framefault}, 72'd0);
`endif
    tick(1'b0, 1'b1, 8'd0);
    tick(1'b0, 1'b1, 8'd0);
    reset = 1'b1;
    blank(2, 1'b0);

    // Continuous ramp frame x+16y.
    nstrobe = 0;
    frame(H, 1'b0, 0);
    blank(4, 1'b0);
    chk("f1_strobes", 72'(nstrobe), 72'd24);
    chk("f1_first_window", first_win, 72'h222120121110020100);
    chk("f1_first_cx", 72'(first_cx), 72'd1);
    chk("f1_first_cy", 72'(first_cy), 72'd1);
    chk("f1_last_cx", 72'(bus.centerx), 72'd6);
    chk("f1_last_cy", 72'(bus.centery), 72'd4);
`ifdef WINDOW_FRAME_CHECK_EN
    chk("f1_framefault", {71'd0, framefault}, 72'd0);
`endif

    // Same frame shape with random valid gaps.
    nstrobe = 0;
    frame(H, 1'b1, 8'h80);
    blank(4, 1'b0);
    chk("gap_strobes", 72'(nstrobe), 72'd24);

    // valid during blanking is ignored.
    nstrobe = 0;
    blank(20, 1'b1);
    chk("blankvalid_strobes", 72'(nstrobe), 72'd0);
    chk("blankvalid_cx_hold", 72'(bus.centerx), 72'd6);
    chk("blankvalid_cy_hold", 72'(bus.centery), 72'd4);

    // Short frame (3 rows) then full frame.
    nstrobe = 0;
    frame(3, 1'b0, 8'h40);
    blank(3, 1'b0);
    chk("short_strobes", 72'(nstrobe), 72'd6);
`ifdef WINDOW_FRAME_CHECK_EN
    chk("short_framefault", {71'd0, framefault}, 72'd1);
`endif
    nstrobe = 0;
    frame(H, 1'b0, 8'h20);
    blank(4, 1'b0);
    chk("after_short_strobes", 72'(nstrobe), 72'd24);

    // Reset mid-row 4 with windows in flight.
    frame(4, 1'b0, 0);
    for (int xx = 0; xx < 3; xx++) tick(1'b1, 1'b0, 8'(xx + 64));
    reset = 1'b0;
    #1;
    chk("midreset_window", bus.window, 72'd0);
    chk("midreset_windowvalid", {71'd0, bus.windowvalid}, 72'd0);
    chk("midreset_centerx", 72'(bus.centerx), 72'd0);
    chk("midreset_centery", 72'(bus.centery), 72'd0);
`ifdef WINDOW_FRAME_CHECK_EN
    chk("midreset_framefault", {71'd0, framefault}, 72'd0);
`endif
    q.delete();
    tx = 0; ty = 0; tfull = 1'b0;
    tick(1'b0, 1'b0, 8'd0);
    tick(1'b0, 1'b0, 8'd0);
    reset = 1'b1;

    // Full frame after reset, then overrun pixels before blanking.
    nstrobe = 0;
    frame(H, 1'b0, 0);
    for (int k = 0; k < 3; k++) tick(1'b1, 1'b0, 8'(k + 200));
    blank(4, 1'b0);
    chk("postreset_strobes", 72'(nstrobe), 72'd24);
    chk("postreset_last_cx", 72'(bus.centerx), 72'd6);
    chk("postreset_last_cy", 72'(bus.centery), 72'd4);
`ifdef WINDOW_FRAME_CHECK_EN
    chk("overrun_framefault", {71'd0, framefault}, 72'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end
endmodule

// File: doc/window_generator.md
# window_generator

Streaming 3x3 neighbourhood generator sitting directly downstream of the Downsampler in the feature-detection pipeline. It consumes the decimated 8-bit pixel stream (`valid`/`data`/`blankingregion`), keeps the two previous image lines in on-chip line buffers, and emits one full 3x3 window plus centre coordinates per interior pixel to the detector stages.

## Interface
- `WIDTH`, 400, active pixels per decimated line
- `HEIGHT`, 300, active lines per decimated frame
- `PIX_W`, 8, pixel width in bits
- `clock`  in  1  single clock; all logic on the rising edge
- `reset`  in  1  asynchronous, active-low reset
- `valid`  in  1  `data` carries a pixel this cycle
- `data`  in  PIX_W  pixel value
- `blankingregion`  in  1  high outside the active frame
- `window`  out  9*PIX_W  3x3 neighbourhood; element (r,c) at bits `[PIX_W*(3r+c) +: PIX_W]`; r=0 oldest row, c=0 leftmost column
- `windowvalid`  out  1  one-cycle strobe, `window`/`centerx`/`centery` valid
- `centerx`  out  clog2(WIDTH)  column of window centre
- `centery`  out  clog2(HEIGHT)  row of window centre

## Operation
- Pixel accepted when `valid`=1 and `blankingregion`=0; `valid` while blanking is ignored.
- Counters x (0..WIDTH-1) and y (0..HEIGHT-1) give the accepted pixel's position. x wraps to 0 and y increments after x=WIDTH-1.
- Any cycle with `blankingregion`=1 clears x and y; the next accepted pixel is (0,0). Line-buffer contents are not cleared.
- Line buffer A holds row y-1 and buffer B holds row y-2, both indexed by x. On accept: read A[x] and B[x], write `data` to A[x], write old A[x] to B[x].
- The 3x3 shift register advances one column only on an accepted pixel. Gaps in `valid` stall it without corrupting it.
- A window is emitted for accepted pixel (x,y) only when x>=2 and y>=2. Centre = (x-1,y-1), so centres span 1..WIDTH-2 by 1..HEIGHT-2. That is (WIDTH-2)*(HEIGHT-2) windows per frame: 118604 at default parameters.
- Window columns never straddle a line wrap: x>=2 guarantees all three columns belong to the current line.
- Overrun: pixels accepted after (WIDTH-1,HEIGHT-1) and before blanking are dropped. y saturates and no windows are emitted.
- Short frame: blanking before the frame completes simply restarts the counters. No window ever mixes stale rows because y<2 suppresses output.

## Timing
- Reset values: `window`=0, `windowvalid`=0, `centerx`=0, `centery`=0, counters 0, pipeline valids 0.
- Latency is fixed at 2 cycles. Pixel accepted at edge N gives `windowvalid`=1 in the cycle after edge N+2.
  - Stage 1: line-buffer read plus input register.
  - Stage 2: column shift plus output register.
- `windowvalid` is high for exactly one cycle per emitted window. `window`/`centerx`/`centery` hold their last values otherwise.
- Throughput is one window per cycle. There is no backpressure; downstream must accept every strobe.
- Blanking asserted while windows are in flight: windows already in stages 1–2 still emerge. Counter clear does not flush them.
- `reset` asserted mid-frame clears all outputs immediately and asynchronously. After release, the next pixel is (0,0).

## Configuration
- `WINDOW_FRAME_CHECK_EN` defined: adds output `framefault` (1 bit, reset 0).
  - Sticky high when `blankingregion` rises after a nonzero but incomplete pixel count, or when a pixel is dropped by overrun.
  - Cleared only by `reset`.
- Not defined: no `framefault` port and no pixel-count logic; behaviour is otherwise identical.

## Structure
- Shared package `window_pkg`:
  - `PIX_W`
  - window size constant `WIN_N`=3
  - coordinate-width localparams
  - function returning the bit offset of element (r,c)
- Sub-module `line_buffer`: single-port synchronous RAM, WIDTH x PIX_W, read-before-write (same-address read returns old data), 1-cycle read latency. Instantiated twice.

## Test plan
- WIDTH=8, HEIGHT=6, continuous `valid`, data=x+16y:
  - First strobe 2 cycles after pixel (2,2), with centre (1,1) and window elements r0={00,01,02}, r1={10,11,12}, r2={20,21,22}.
  - Exactly 24 strobes in the frame; last centre is (6,4).
- Same frame with pseudo-random 50% `valid` gaps -> identical window/centre sequence; strobes appear only 2 cycles after accepts.
- `blankingregion` pulsed after row 3 of 6, then a full frame -> no strobe until new pixel (2,2); with `WINDOW_FRAME_CHECK_EN`, `framefault`=1.
- `valid`=1 with `blankingregion`=1 for 20 cycles -> no accepts, no strobes, counters stay 0.
- `reset` low mid-row 4 -> all outputs 0 in the same cycle; full frame after release yields the same 24 windows as the first scenario.
- Default 400x300 frame of ramp data -> 118604 strobes, first centre (1,1), last (398,298), `framefault`=0.
